// File: rtl/tri_debug_pkg.sv
// Shared types and constants for the debug trace capture endpoint.
// Holds the capture state encoding, coretrace control bit positions and timestamp width.
package tri_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } cap_state_t;

  localparam int QUAL     = 0;
  localparam int EXT_TRIG = 1;
  localparam int TS_W     = 16;

endpackage

// File: rtl/tri_debug_trace_ram.sv
// Trace buffer storage: one write port, one read port with a registered, enable-held output.
// Read latency 1; output clears on rst and otherwise holds when rd_en is low.
module tri_debug_trace_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/tri_debug_trace_capture.sv
// Debug trace capture: triggered circular buffer with post-trigger window and oldest-first readout.
// Read latency 1, one read per cycle; optional per-entry timestamp under TRI_DBG_CAPTURE_TIMESTAMP_EN.
module tri_debug_trace_capture import tri_debug_pkg::*; #(
  parameter int DBG_WIDTH = 32,
  parameter int DEPTH     = 64,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DBG_WIDTH-1:0] trace_data_in,
  input  logic [3:0]           coretrace_ctrls_in,
  input  logic                 arm,
  input  logic                 stop,
  input  logic [DBG_WIDTH-1:0] trig_mask,
  input  logic [DBG_WIDTH-1:0] trig_pattern,
  input  logic [AW-1:0]        post_trig_cnt,
  input  logic                 rd_req,
  output logic                 rd_valid,
  output logic [DBG_WIDTH-1:0] rd_data,
  output logic                 rd_empty,
  output logic                 busy,
  output logic                 triggered,
  output logic                 done,
  output logic [AW:0]          fill_cnt
`ifdef TRI_DBG_CAPTURE_TIMESTAMP_EN
  ,
  output logic [0:15]          rd_timestamp
`endif
);

`ifdef TRI_DBG_CAPTURE_TIMESTAMP_EN
  localparam int L_EXTRA = TS_W;
`else
  localparam int L_EXTRA = 0;
`endif
  localparam int        L_RW   = DBG_WIDTH + L_EXTRA;
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  cap_state_t r_state, w_next_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_fill;
  logic            r_trig;
  logic [AW-1:0]   r_post_rem;
  logic [AW:0]     r_rd_cnt;
  logic            r_rd_valid;

  logic            w_capturing, w_qual, w_match, w_trig, w_we;
  logic            w_rd_empty, w_rd_fire;
  logic [AW-1:0]   w_rd_base, w_rd_addr;
  logic [L_RW-1:0] w_wr_word, w_rd_word;
  logic            w_unused_ctrls;

  assign w_unused_ctrls = ^coretrace_ctrls_in[3:2];

  assign w_capturing = (r_state == ST_ARMED) || (r_state == ST_POST);
  assign w_qual      = coretrace_ctrls_in[QUAL] && w_capturing;
  assign w_match     = (trig_mask != '0) &&
                       ((trace_data_in & trig_mask) == (trig_pattern & trig_mask));
  assign w_trig      = (r_state == ST_ARMED) && w_qual &&
                       (w_match || coretrace_ctrls_in[EXT_TRIG]);
  // arm clears the buffer, so a sample arriving alongside it is discarded
  assign w_we        = w_qual && !arm;

  always_comb begin
    w_next_state = r_state;
    if (arm) begin
      w_next_state = ST_ARMED;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_trig && (post_trig_cnt != '0) && !stop) w_next_state = ST_POST;
          else if (w_trig || stop)                      w_next_state = ST_DONE;
        end
        ST_POST: begin
          if (stop || (w_qual && (r_post_rem == AW'(1)))) w_next_state = ST_DONE;
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      r_trig     <= 1'b0;
      r_post_rem <= '0;
    end else if (arm) begin
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      r_trig     <= 1'b0;
    end else if (w_we) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_fill != L_FULL) r_fill <= r_fill + 1'b1;
      if (w_trig) begin
        r_trig     <= 1'b1;
        r_post_rem <= post_trig_cnt;
      end else if (r_state == ST_POST) begin
        r_post_rem <= r_post_rem - 1'b1;
      end
    end
  end

  // Once the buffer has wrapped, the oldest entry sits at the write pointer
  assign w_rd_base  = r_fill[AW] ? r_wr_ptr : '0;
  assign w_rd_addr  = w_rd_base + r_rd_cnt[AW-1:0];
  assign w_rd_empty = (r_state == ST_DONE) && (r_rd_cnt == r_fill);
  assign w_rd_fire  = rd_req && (r_state == ST_DONE) && !w_rd_empty && !arm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (arm)            r_rd_cnt <= '0;
      else if (w_rd_fire) r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

`ifdef TRI_DBG_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  assign w_wr_word    = {r_ts, trace_data_in};
  assign rd_timestamp = w_rd_word[L_RW-1 -: TS_W];
`else
  assign w_wr_word    = trace_data_in;
`endif

  tri_debug_trace_ram #(
    .WIDTH (L_RW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_we),
    .wr_addr (r_wr_ptr),
    .wr_data (w_wr_word),
    .rd_en   (w_rd_fire),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_word)
  );

  assign rd_data   = w_rd_word[DBG_WIDTH-1:0];
  assign rd_valid  = r_rd_valid;
  assign rd_empty  = w_rd_empty;
  assign busy      = w_capturing;
  assign triggered = r_trig;
  assign done      = (r_state == ST_DONE);
  assign fill_cnt  = r_fill;

endmodule

// File: tb/tb_tri_debug_trace_capture.sv
// Bench for tri_debug_trace_capture: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tri_debug_trace_capture;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] trace_data_in;
  logic [3:0]  coretrace_ctrls_in;
  logic        arm, stop;
  logic [31:0] trig_mask, trig_pattern;
  logic [5:0]  post_trig_cnt;
  logic        rd_req;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_empty, busy, triggered, done;
  logic [6:0]  fill_cnt;
`ifdef TRI_DBG_CAPTURE_TIMESTAMP_EN
  logic [0:15] rd_timestamp;
`endif

  tri_debug_trace_capture #(.DBG_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .trace_data_in      (trace_data_in),
    .coretrace_ctrls_in (coretrace_ctrls_in),
    .arm                (arm),
    .stop               (stop),
    .trig_mask          (trig_mask),
    .trig_pattern       (trig_pattern),
    .post_trig_cnt      (post_trig_cnt),
    .rd_req             (rd_req),
    .rd_valid           (rd_valid),
    .rd_data            (rd_data),
    .rd_empty           (rd_empty),
    .busy               (busy),
    .triggered          (triggered),
    .done               (done),
    .fill_cnt           (fill_cnt)
`ifdef TRI_DBG_CAPTURE_TIMESTAMP_EN
    ,
    .rd_timestamp       (rd_timestamp)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ARMED = 1, M_POST = 2, M_DONE = 3;
  int          m_state = M_IDLE;
  logic [31:0] m_q[$];
  logic        m_trig = 1'b0;
  int          m_rem = 0;
  int          m_rd_idx = 0;
  logic        m_rd_valid = 1'b0;
  logic [31:0] m_rd_data = '0;
  logic        m_qual, m_hit;

  always @(posedge clk) begin
    m_qual = coretrace_ctrls_in[0] && (m_state == M_ARMED || m_state == M_POST);
    m_hit  = ((trig_mask != 0) && ((trace_data_in & trig_mask) == (trig_pattern & trig_mask)))
             || coretrace_ctrls_in[1];
    if (rst) begin
      m_state = M_IDLE; m_q.delete(); m_trig = 0; m_rd_idx = 0;
      m_rd_valid = 0; m_rd_data = '0;
    end else if (arm) begin
      m_state = M_ARMED; m_q.delete(); m_trig = 0; m_rd_idx = 0; m_rd_valid = 0;
    end else begin
      m_rd_valid = 0;
      if (m_qual) begin
        m_q.push_back(trace_data_in);
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
      end
      case (m_state)
        M_ARMED: begin
          if (m_qual && m_hit) begin
            m_trig = 1;
            m_rem  = int'(post_trig_cnt);
            m_state = (m_rem == 0 || stop) ? M_DONE : M_POST;
          end else if (stop) m_state = M_DONE;
        end
        M_POST: begin
          if (m_qual) m_rem--;
          if (stop || m_rem == 0) m_state = M_DONE;
        end
        M_DONE: begin
          if (rd_req && m_rd_idx < m_q.size()) begin
            m_rd_data = m_q[m_rd_idx];
            m_rd_idx++;
            m_rd_valid = 1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [31:0] got[$];

  always @(negedge clk) begin
    chk("busy", busy, (m_state == M_ARMED || m_state == M_POST));
    chk("done", done, (m_state == M_DONE));
    chk("triggered", triggered, m_trig);
    chk("fill_cnt", fill_cnt, m_q.size());
    chk("rd_empty", rd_empty, (m_state == M_DONE && m_rd_idx == m_q.size()));
    chk("rd_valid", rd_valid, m_rd_valid);
    chk("rd_data", rd_data, m_rd_data);
    if (rd_valid) got.push_back(rd_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [31:0] d, input logic q, input logic ext);
    trace_data_in      = d;
    coretrace_ctrls_in = {2'b00, ext, q};
    tick();
    coretrace_ctrls_in = 4'h0;
  endtask

  task automatic do_arm();
    arm = 1; tick(); arm = 0;
  endtask

  task automatic do_stop();
    stop = 1; tick(); stop = 0;
  endtask

  task automatic read_n(input int n);
    got.delete();
    rd_req = 1;
    repeat (n) tick();
    rd_req = 0;
    tick();
  endtask

  initial begin
    rst = 1; trace_data_in = '0; coretrace_ctrls_in = '0; arm = 0; stop = 0;
    trig_mask = '0; trig_pattern = '0; post_trig_cnt = '0; rd_req = 0;
    repeat (2) tick();
    rst = 0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_fill", fill_cnt, 0);
    chk("reset_rd_data", rd_data, 0);

    // 1: ten samples then stop, plain readout
    do_arm();
    for (int i = 0; i < 10; i++) sample(i, 1, 0);
    do_stop();
    chk("t1_done", done, 1);
    chk("t1_fill", fill_cnt, 10);
    read_n(10);
    chk("t1_nread", got.size(), 10);
    for (int k = 0; k < 10 && k < got.size(); k++) chk("t1_data", got[k], k);
    chk("t1_empty", rd_empty, 1);
    rd_req = 1; tick(); rd_req = 0;
    chk("t1_rd_when_empty", rd_valid, 0);

    // 2: pattern trigger at 80, five post samples, wrapped buffer
    trig_mask = 32'hFFFF_FFFF; trig_pattern = 32'd80; post_trig_cnt = 6'd5;
    do_arm();
    for (int i = 0; i < 100; i++) begin
      sample(i, 1, 0);
      if (i == 84) chk("t2_not_done_84", done, 0);
      if (i == 85) chk("t2_done_85", done, 1);
    end
    chk("t2_fill", fill_cnt, 64);
    read_n(64);
    chk("t2_nread", got.size(), 64);
    for (int k = 0; k < 64 && k < got.size(); k++) chk("t2_data", got[k], 22 + k);

    // 3: unqualified samples neither stored, triggered on, nor counted
    trig_pattern = 32'h100; post_trig_cnt = 6'd3;
    do_arm();
    sample(32'h100, 0, 0);
    chk("t3_no_trig_unqual", triggered, 0);
    sample(32'h200, 1, 0);
    sample(32'hdead, 0, 0);
    sample(32'h100, 1, 0);
    sample(32'hbad, 0, 0);
    sample(32'h201, 1, 0);
    sample(32'hbad2, 0, 0);
    sample(32'h202, 1, 0);
    chk("t3_not_done", done, 0);
    sample(32'h203, 1, 0);
    chk("t3_done", done, 1);
    sample(32'h204, 1, 0);
    chk("t3_fill", fill_cnt, 5);
    read_n(5);
    chk("t3_nread", got.size(), 5);
    if (got.size() == 5) begin
      chk("t3_d0", got[0], 32'h200);
      chk("t3_d1", got[1], 32'h100);
      chk("t3_d2", got[2], 32'h201);
      chk("t3_d3", got[3], 32'h202);
      chk("t3_d4", got[4], 32'h203);
    end

    // 4: external trigger on sample 3 with zero post window
    trig_mask = '0; post_trig_cnt = 6'd0;
    do_arm();
    sample(32'h77, 0, 1);
    for (int i = 0; i < 3; i++) sample(i, 1, 0);
    chk("t4_trig_before", triggered, 0);
    sample(3, 1, 1);
    chk("t4_done", done, 1);
    chk("t4_fill", fill_cnt, 4);
    chk("t4_triggered", triggered, 1);

    // 5: arm and stop together during POST
    trig_mask = 32'hFFFF_FFFF; trig_pattern = 32'd5; post_trig_cnt = 6'd10;
    do_arm();
    for (int i = 0; i < 8; i++) sample(i, 1, 0);
    chk("t5_in_post", busy, 1);
    arm = 1; stop = 1; tick(); arm = 0; stop = 0;
    chk("t5_busy", busy, 1);
    chk("t5_done", done, 0);
    chk("t5_fill", fill_cnt, 0);
    chk("t5_triggered", triggered, 0);
    rd_req = 1;
    tick(); chk("t5_rd_armed_a", rd_valid, 0);
    tick(); chk("t5_rd_armed_b", rd_valid, 0);
    rd_req = 0;

    // 6: reset in POST with 20 entries, then a fresh capture
    trig_pattern = 32'd15; post_trig_cnt = 6'd30;
    do_arm();
    for (int i = 0; i < 20; i++) sample(i, 1, 0);
    chk("t6_fill_pre", fill_cnt, 20);
    chk("t6_trig_pre", triggered, 1);
    rst = 1; tick(); rst = 0;
    chk("t6_busy", busy, 0);
    chk("t6_triggered", triggered, 0);
    chk("t6_done", done, 0);
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_rd_empty", rd_empty, 0);
    chk("t6_fill", fill_cnt, 0);
    chk("t6_rd_data", rd_data, 0);
    trig_mask = '0;
    do_arm();
    for (int i = 0; i < 5; i++) sample(32'ha0 + i, 1, 0);
    do_stop();
    chk("t6_fill_new", fill_cnt, 5);
    read_n(5);
    chk("t6_nread", got.size(), 5);
    for (int k = 0; k < 5 && k < got.size(); k++) chk("t6_data", got[k], 32'ha0 + k);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
